// File: rtl/cache_ctrl_v2.sv
// Split I/D cache controller: single-cycle hits, round-robin miss service with dirty write-back then line fill.
// ready drops for the whole miss; the memory side is a simple strobe held until m_rdy.
module cache_ctrl_v2 #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int WORDS  = 4,
  parameter int TAG_W  = 8,
  parameter int CNT_W  = 16,
  localparam int OFF_W  = $clog2(WORDS),
  localparam int LINE_W = WORDS * WORD_W,
  localparam int MA_W   = ADDR_W - OFF_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic              we,
  input  logic              i_fetch,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] wrt_data,
  input  logic              i_hit,
  input  logic              d_hit,
  input  logic              d_dirty,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic [LINE_W-1:0] i_out,
  input  logic [LINE_W-1:0] d_out,
  input  logic [LINE_W-1:0] m_out,
  input  logic              m_rdy,
  output logic              ready,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] rd_data,
  output logic              i_we,
  output logic              d_we,
  output logic [LINE_W-1:0] i_data,
  output logic [LINE_W-1:0] d_data,
  output logic              d_dirty_in,
  output logic              m_re,
  output logic              m_we,
  output logic [MA_W-1:0]   m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  i_miss_cnt,
  output logic [CNT_W-1:0]  d_miss_cnt
);

  typedef enum logic [1:0] {CHECK, WRITE_BACK, MEM_READ} state_t;

  state_t             r_state, w_next;
  logic               r_rr_i;      // 1: instruction side wins the next double miss
  logic               r_side_i;
  logic               r_we;
  logic [ADDR_W-1:0]  r_addr;
  logic [WORD_W-1:0]  r_wdata;
  logic [TAG_W-1:0]   r_tag;
  logic [LINE_W-1:0]  r_line;
  logic [CNT_W-1:0]   r_i_cnt, r_d_cnt;

  logic w_d_miss, w_i_miss, w_exit, w_serve_i;

  function automatic logic [WORD_W-1:0] f_word(input logic [LINE_W-1:0] line,
                                               input logic [OFF_W-1:0]  off);
    f_word = '0;
    for (int k = 0; k < WORDS; k++)
      if (off == OFF_W'(k)) f_word = line[k*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] f_merge(input logic [LINE_W-1:0] line,
                                                input logic [OFF_W-1:0]  off,
                                                input logic [WORD_W-1:0] w);
    f_merge = line;
    for (int k = 0; k < WORDS; k++)
      if (off == OFF_W'(k)) f_merge[k*WORD_W +: WORD_W] = w;
  endfunction

  assign instr      = f_word(i_out, i_addr[OFF_W-1:0]);
  assign rd_data    = f_word(d_out, d_addr[OFF_W-1:0]);
  assign w_d_miss   = (re | we) & ~d_hit;
  assign w_i_miss   = i_fetch & ~i_hit;
  assign w_serve_i  = w_i_miss & (~w_d_miss | r_rr_i);
  assign w_exit     = (r_state == CHECK) & (w_d_miss | w_i_miss);
  assign i_miss_cnt = r_i_cnt;
  assign d_miss_cnt = r_d_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= CHECK;
      r_rr_i   <= 1'b0;
      r_side_i <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_tag    <= '0;
      r_line   <= '0;
      r_i_cnt  <= '0;
      r_d_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_exit) begin
        r_side_i <= w_serve_i;
        r_rr_i   <= ~w_serve_i;
        r_addr   <= w_serve_i ? i_addr : d_addr;
        r_we     <= we;
        r_wdata  <= wrt_data;
        r_tag    <= d_tag;
        r_line   <= d_out;
      end
      if (clr_stats) begin
        r_i_cnt <= '0;
        r_d_cnt <= '0;
      end else if (w_exit) begin
        if (w_serve_i && !(&r_i_cnt)) r_i_cnt <= r_i_cnt + CNT_W'(1);
        if (!w_serve_i && !(&r_d_cnt)) r_d_cnt <= r_d_cnt + CNT_W'(1);
      end
    end
  end

  // Outputs are forced idle while rst is high so an aborted fill never writes an array.
  always_comb begin
    w_next     = r_state;
    ready      = 1'b0;
    i_we       = 1'b0;
    d_we       = 1'b0;
    i_data     = '0;
    d_data     = '0;
    d_dirty_in = 1'b0;
    m_re       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    if (!rst) begin
      case (r_state)
        CHECK: begin
          if (!w_exit) begin
            ready = 1'b1;
            if (we) begin
              d_we       = 1'b1;
              d_dirty_in = 1'b1;
              d_data     = f_merge(d_out, d_addr[OFF_W-1:0], wrt_data);
            end
          end else if (!w_serve_i && d_dirty) begin
            w_next = WRITE_BACK;
          end else begin
            w_next = MEM_READ;
          end
        end
        WRITE_BACK: begin
          m_we    = 1'b1;
          m_addr  = {r_tag, r_addr[ADDR_W-TAG_W-1:OFF_W]};
          m_wdata = r_line;
          if (m_rdy) w_next = MEM_READ;
        end
        MEM_READ: begin
          m_re   = 1'b1;
          m_addr = r_addr[ADDR_W-1:OFF_W];
          if (m_rdy) begin
            w_next = CHECK;
            if (r_side_i) begin
              i_we   = 1'b1;
              i_data = m_out;
            end else begin
              d_we       = 1'b1;
              d_dirty_in = r_we;
              d_data     = r_we ? f_merge(m_out, r_addr[OFF_W-1:0], r_wdata) : m_out;
            end
          end
        end
        default: w_next = CHECK;
      endcase
    end
  end

endmodule
